// File: rtl/text_buf_cmd_ctrl_if.sv
// Command and buffer-write bundle between a requester and text_buf_cmd_ctrl.
// Master issues commands; slave (the controller) drives the buffer RAM write ports.
interface text_buf_cmd_ctrl_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  cmd_valid;
  logic [1:0]            cmd_code;
  logic [7:0]            cmd_data;
  logic                  cmd_ready;
  logic                  char_we;
  logic [ADDR_WIDTH-1:0] char_addr;
  logic [7:0]            char_data;
  logic                  color_we;
  logic [ADDR_WIDTH-1:0] color_addr;
  logic [7:0]            color_data;
  logic [ADDR_WIDTH-1:0] cursor;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_code, cmd_data,
    input  cmd_ready, char_we, char_addr, char_data,
    input  color_we, color_addr, color_data, cursor, busy
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_data,
    output cmd_ready, char_we, char_addr, char_data,
    output color_we, color_addr, color_data, cursor, busy
  );
endinterface

// File: rtl/text_buf_cmd_ctrl.sv
// Text-mode buffer command sequencer: cursor/attribute owner, single-cell stores and clear sweep.
// Optional macro TEXT_CTRL_NEWLINE_EN: STORE of 8'h0A advances the cursor to the next row instead of writing.
module text_buf_cmd_ctrl #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 60,
  parameter int         ADDR_WIDTH = 13,
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter logic [7:0] RESET_ATTR = 8'h0F
) (
  input logic               clk,
  input logic               rst,
  text_buf_cmd_ctrl_if.slave bus
);

  localparam int CELLS = COLS * ROWS;
  localparam int SW    = ADDR_WIDTH + 2;
  localparam int NW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(CELLS - 1);
  localparam logic signed [SW-1:0]  COLS_S  = SW'(COLS);
  localparam logic signed [SW-1:0]  CELLS_S = SW'(CELLS);

  localparam logic [1:0] CMD_STORE    = 2'b00;
  localparam logic [1:0] CMD_MOVE     = 2'b01;
  localparam logic [1:0] CMD_SET_ATTR = 2'b10;
  localparam logic [1:0] CMD_CLEAR    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [ADDR_WIDTH-1:0]  r_cursor;
  logic [7:0]             r_attr;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [7:0]             r_charData;
  logic [7:0]             r_colorData;

  logic                   w_accept;
  logic                   w_isNewline;
  logic [ADDR_WIDTH-1:0]  w_cursorInc;
  logic [ADDR_WIDTH-1:0]  w_moveCursor;
  logic [ADDR_WIDTH-1:0]  w_nlCursor;
  logic signed [SW-1:0]   w_offset;
  logic signed [SW-1:0]   w_sum;
  logic signed [SW-1:0]   w_adj;

  assign w_accept    = bus.cmd_valid && bus.cmd_ready;
  assign w_cursorInc = (r_cursor == LAST) ? '0 : r_cursor + ADDR_WIDTH'(1);

`ifdef TEXT_CTRL_NEWLINE_EN
  logic [NW-1:0] w_nlNext;
  assign w_isNewline = (bus.cmd_code == CMD_STORE) && (bus.cmd_data == 8'h0A);
  assign w_nlNext    = (NW'(r_cursor) / NW'(COLS) + NW'(1)) * NW'(COLS);
  assign w_nlCursor  = (w_nlNext >= NW'(CELLS)) ? '0 : ADDR_WIDTH'(w_nlNext);
`else
  assign w_isNewline = 1'b0;
  assign w_nlCursor  = r_cursor;
`endif

  // MOVE offset is either a signed cell count or a signed row count scaled by COLS;
  // a single wrap correction is enough since |offset| < CELLS.
  always_comb begin
    w_offset = '0;
    if (bus.cmd_data[7]) begin
      w_offset = SW'($signed(bus.cmd_data[6:0]));
    end else begin
      w_offset = SW'($signed(bus.cmd_data[5:0])) * COLS_S;
    end
    w_sum = $signed({2'b00, r_cursor}) + w_offset;
    if (w_sum[SW-1]) begin
      w_adj = w_sum + CELLS_S;
    end else if (w_sum >= CELLS_S) begin
      w_adj = w_sum - CELLS_S;
    end else begin
      w_adj = w_sum;
    end
  end

  assign w_moveCursor = ADDR_WIDTH'(w_adj);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.cmd_code == CMD_STORE && !w_isNewline) begin
            w_nextState = S_WRITE;
          end else if (bus.cmd_code == CMD_CLEAR) begin
            w_nextState = S_CLEAR;
          end
        end
      end
      S_WRITE: w_nextState = S_IDLE;
      S_CLEAR: begin
        if (r_addr == LAST) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // During CLEAR r_addr doubles as the sweep counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cursor    <= '0;
      r_attr      <= RESET_ATTR;
      r_addr      <= '0;
      r_charData  <= '0;
      r_colorData <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (bus.cmd_code)
              CMD_STORE: begin
                if (w_isNewline) begin
                  r_cursor <= w_nlCursor;
                end else begin
                  r_addr      <= r_cursor;
                  r_charData  <= bus.cmd_data;
                  r_colorData <= r_attr;
                  r_cursor    <= w_cursorInc;
                end
              end
              CMD_MOVE:     r_cursor <= w_moveCursor;
              CMD_SET_ATTR: r_attr   <= bus.cmd_data;
              CMD_CLEAR: begin
                r_addr      <= '0;
                r_charData  <= CLEAR_CHAR;
                r_colorData <= r_attr;
              end
              default: ;
            endcase
          end
        end
        S_CLEAR: begin
          if (r_addr == LAST) begin
            r_addr   <= '0;
            r_cursor <= '0;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready  = (r_state == S_IDLE) && rst;
  assign bus.char_we    = (r_state != S_IDLE);
  assign bus.color_we   = (r_state != S_IDLE);
  assign bus.char_addr  = r_addr;
  assign bus.color_addr = r_addr;
  assign bus.char_data  = r_charData;
  assign bus.color_data = r_colorData;
  assign bus.cursor     = r_cursor;
  assign bus.busy       = (r_state == S_CLEAR);

endmodule

// File: tb/tb_text_buf_cmd_ctrl.sv
// Directed testbench for text_buf_cmd_ctrl; inputs change and outputs are sampled on the falling edge.
// Honours TEXT_CTRL_NEWLINE_EN the same way the design does.
module tb_text_buf_cmd_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  text_buf_cmd_ctrl_if #(.ADDR_WIDTH(13)) bus ();

  text_buf_cmd_ctrl #(
    .COLS(80), .ROWS(60), .ADDR_WIDTH(13), .CLEAR_CHAR(8'h20), .RESET_ATTR(8'h0F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one command for a single edge; returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic [1:0] code, input logic [7:0] data);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int bad;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 2'b00;
    bus.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);

    checkOutput("rst_ready",  32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_we",     32'(bus.char_we),   32'd0);
    checkOutput("rst_cwe",    32'(bus.color_we),  32'd0);
    checkOutput("rst_busy",   32'(bus.busy),      32'd0);
    checkOutput("rst_cursor", 32'(bus.cursor),    32'd0);
    checkOutput("rst_addr",   32'(bus.char_addr), 32'd0);
    checkOutput("rst_data",   32'(bus.char_data), 32'd0);
    checkOutput("rst_cdata",  32'(bus.color_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 32'(bus.cmd_ready), 32'd1);

    applyStimulus(2'b00, 8'h41);
    checkOutput("st41_we",     32'(bus.char_we),    32'd1);
    checkOutput("st41_cwe",    32'(bus.color_we),   32'd1);
    checkOutput("st41_addr",   32'(bus.char_addr),  32'd0);
    checkOutput("st41_caddr",  32'(bus.color_addr), 32'd0);
    checkOutput("st41_data",   32'(bus.char_data),  32'h41);
    checkOutput("st41_cdata",  32'(bus.color_data), 32'h0F);
    checkOutput("st41_cursor", 32'(bus.cursor),     32'd1);
    checkOutput("st41_ready",  32'(bus.cmd_ready),  32'd0);
    @(negedge clk);
    checkOutput("st41_we_off", 32'(bus.char_we),    32'd0);
    checkOutput("st41_rdy_on", 32'(bus.cmd_ready),  32'd1);

    applyStimulus(2'b01, 8'hFF);
    checkOutput("mv_m1cell",   32'(bus.cursor),     32'd0);
    checkOutput("mv_no_we",    32'(bus.char_we),    32'd0);
    checkOutput("mv_ready",    32'(bus.cmd_ready),  32'd1);
    applyStimulus(2'b01, 8'h3F);
    checkOutput("mv_m1row",    32'(bus.cursor),     32'd4720);
    applyStimulus(2'b01, 8'h01);
    checkOutput("mv_p1row_wr", 32'(bus.cursor),     32'd0);
    applyStimulus(2'b01, 8'h8A);
    checkOutput("mv_p10",      32'(bus.cursor),     32'd10);
    applyStimulus(2'b01, 8'hC0);
    checkOutput("mv_m64",      32'(bus.cursor),     32'd4746);
    applyStimulus(2'b01, 8'hAC);
    checkOutput("mv_p44",      32'(bus.cursor),     32'd4790);
    applyStimulus(2'b01, 8'h01);
    checkOutput("mv_p1row",    32'(bus.cursor),     32'd70);
    applyStimulus(2'b01, 8'h7F);
    checkOutput("mv_bit6_ign", 32'(bus.cursor),     32'd4790);

    applyStimulus(2'b01, 8'h80 | 8'h09);
    checkOutput("mv_p9",       32'(bus.cursor),     32'd4799);
    applyStimulus(2'b00, 8'h5A);
    checkOutput("st5a_addr",   32'(bus.char_addr),  32'd4799);
    checkOutput("st5a_data",   32'(bus.char_data),  32'h5A);
    checkOutput("st5a_cursor", 32'(bus.cursor),     32'd0);

    applyStimulus(2'b10, 8'h1E);
    checkOutput("attr_no_we",  32'(bus.char_we),    32'd0);
    applyStimulus(2'b11, 8'h00);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 2'b00;
    bus.cmd_data  = 8'h55;
    bad = 0;
    for (int i = 0; i < 4800; i++) begin
      if (!(bus.char_we === 1'b1 && bus.color_we === 1'b1 && bus.busy === 1'b1 &&
            bus.cmd_ready === 1'b0 && bus.char_addr === 13'(i) && bus.color_addr === 13'(i) &&
            bus.char_data === 8'h20 && bus.color_data === 8'h1E)) begin
        bad++;
      end
      if (i == 4799) bus.cmd_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("clr_bad_cycles", 32'(bad),           32'd0);
    checkOutput("clr_busy_off",   32'(bus.busy),      32'd0);
    checkOutput("clr_we_off",     32'(bus.char_we),   32'd0);
    checkOutput("clr_cursor",     32'(bus.cursor),    32'd0);
    checkOutput("clr_ready",      32'(bus.cmd_ready), 32'd1);

    applyStimulus(2'b00, 8'h42);
    checkOutput("st42_addr",   32'(bus.char_addr),  32'd0);
    checkOutput("st42_cdata",  32'(bus.color_data), 32'h1E);
    checkOutput("st42_cursor", 32'(bus.cursor),     32'd1);

    applyStimulus(2'b11, 8'h00);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 2'b00;
    bus.cmd_data  = 8'h77;
    repeat (100) @(negedge clk);
    checkOutput("clr100_addr", 32'(bus.char_addr), 32'd100);
    checkOutput("clr100_busy", 32'(bus.busy),      32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_we",     32'(bus.char_we),   32'd0);
    checkOutput("abort_busy",   32'(bus.busy),      32'd0);
    checkOutput("abort_cursor", 32'(bus.cursor),    32'd0);
    checkOutput("abort_ready",  32'(bus.cmd_ready), 32'd0);
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    applyStimulus(2'b00, 8'h43);
    checkOutput("st43_addr",   32'(bus.char_addr),  32'd0);
    checkOutput("st43_cdata",  32'(bus.color_data), 32'h0F);
    checkOutput("st43_cursor", 32'(bus.cursor),     32'd1);

    applyStimulus(2'b01, 8'h01);
    applyStimulus(2'b01, 8'h84);
    checkOutput("mv_to85",     32'(bus.cursor),     32'd85);
    applyStimulus(2'b00, 8'h0A);
`ifdef TEXT_CTRL_NEWLINE_EN
    checkOutput("nl_we",       32'(bus.char_we),    32'd0);
    checkOutput("nl_ready",    32'(bus.cmd_ready),  32'd1);
    checkOutput("nl_cursor",   32'(bus.cursor),     32'd160);
    applyStimulus(2'b01, 8'h3D);
    applyStimulus(2'b01, 8'h9E);
    checkOutput("mv_to4750",   32'(bus.cursor),     32'd4750);
    applyStimulus(2'b00, 8'h0A);
    checkOutput("nl_wrap",     32'(bus.cursor),     32'd0);
    checkOutput("nl_wrap_we",  32'(bus.char_we),    32'd0);
`else
    checkOutput("lf_we",       32'(bus.char_we),    32'd1);
    checkOutput("lf_data",     32'(bus.char_data),  32'h0A);
    checkOutput("lf_addr",     32'(bus.char_addr),  32'd85);
    checkOutput("lf_cursor",   32'(bus.cursor),     32'd86);
`endif

    @(negedge clk);
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
